// File: rtl/led_trail_pwm_if.sv
// ----------------------------------------------------------------------------
// led_trail_pwm_if : pattern/enable inputs and LED/sync outputs of led_trail_pwm
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface led_trail_pwm_if;
  logic       en;
  logic [7:0] pattern_n;
  logic [7:0] led_n;
  logic       pwm_sync;

  modport master (output en, pattern_n, input led_n, pwm_sync);
  modport slave  (input en, pattern_n, output led_n, pwm_sync);
endinterface

`default_nettype wire

// File: rtl/led_trail_pwm.sv
// ----------------------------------------------------------------------------
// led_trail_pwm : full-on LEDs while the pattern bit is active, PWM fade trail after
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_trail_pwm #(
  parameter int PWM_DIV    = 8,
  parameter int DECAY_DIV  = 195_313,
  parameter int DECAY_STEP = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  led_trail_pwm_if.slave bus
);

  localparam int            PW         = (PWM_DIV > 1)   ? $clog2(PWM_DIV)   : 1;
  localparam int            DW         = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PW-1:0] PWM_LAST   = PW'(PWM_DIV - 1);
  localparam logic [PW-1:0] PWM_ONE    = PW'(1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_DIV - 1);
  localparam logic [DW-1:0] DECAY_ONE  = DW'(1);
  localparam logic [7:0]    STEP       = 8'(DECAY_STEP);

  logic [PW-1:0] pwm_pre;
  logic [7:0]    pwm_cnt;
  logic [DW-1:0] dec_pre;
  logic [7:0]    level     [8];
  logic [7:0]    level_nxt [8];
  logic [7:0]    lit;
  logic          pwm_step;
  logic          dec_tick;

  assign pwm_step = (pwm_pre == PWM_LAST);
  assign dec_tick = (dec_pre == DECAY_LAST);

  // A pattern load takes priority over a coincident decay tick.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lit[i]       = ~bus.pattern_n[i] | (level[i] > pwm_cnt);
      level_nxt[i] = level[i];
      if (!bus.pattern_n[i])
        level_nxt[i] = 8'hFF;
      else if (dec_tick)
        level_nxt[i] = (level[i] >= STEP) ? (level[i] - STEP) : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      pwm_pre      <= '0;
      pwm_cnt      <= 8'h00;
      dec_pre      <= '0;
      bus.led_n    <= 8'hFF;
      bus.pwm_sync <= 1'b0;
      for (int i = 0; i < 8; i++)
        level[i] <= 8'h00;
    end else begin
      pwm_pre      <= pwm_step ? '0 : (pwm_pre + PWM_ONE);
      pwm_cnt      <= pwm_step ? (pwm_cnt + 8'h01) : pwm_cnt;
      bus.pwm_sync <= pwm_step && (pwm_cnt == 8'hFF);
      dec_pre      <= dec_tick ? '0 : (dec_pre + DECAY_ONE);
      bus.led_n    <= ~lit;
      for (int i = 0; i < 8; i++)
        level[i] <= level_nxt[i];
    end
  end

endmodule

`default_nettype wire
